// File: rtl/distortion_pipe.sv
// rtl/distortion_pipe.sv - 5-stage fixed-point distortion (bypass / hard clip / cubic soft clip); clip counter under DIST_CLIP_STATS_EN
module distortion_pipe #(
  parameter int DATA_W   = 16,
  parameter int GAIN_W   = 16,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] input_,
  input  logic [1:0]               mode,
  input  logic [GAIN_W-1:0]        distortion_gain,
  input  logic [GAIN_W-1:0]        distortion_boost,
  input  logic [DATA_W-2:0]        clip_level,
  input  logic                     clip_clr,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out,
  output logic [15:0]              clip_count
);

  localparam int FS   = 2**(DATA_W-1) - 1;
  localparam int V_W  = DATA_W + 3;            // soft-clip polynomial headroom
  localparam int P1_W = DATA_W + GAIN_W + 1;   // input * gain
  localparam int P5_W = V_W + GAIN_W + 1;      // shaped value * boost
  localparam int SQ_W = 2 * DATA_W;

  localparam logic signed [DATA_W-1:0] D_MAX  = DATA_W'(FS);
  localparam logic signed [DATA_W-1:0] D_MIN  = -D_MAX;
  localparam logic signed [P1_W-1:0]   S1_MAX = P1_W'(FS);
  localparam logic signed [P1_W-1:0]   S1_MIN = -S1_MAX;
  localparam logic signed [P5_W-1:0]   S5_MAX = P5_W'(FS);
  localparam logic signed [P5_W-1:0]   S5_MIN = -S5_MAX;

  // ---------------- S1: pre-gain with symmetric saturation ----------------
  logic signed [P1_W-1:0]   w_s1_x, w_s1_g, w_s1_prod, w_s1_shift;
  logic signed [DATA_W-1:0] w_s1_p;
  logic                     w_s1_sat;
  logic                     w_s1_byp;

  assign w_s1_x     = P1_W'(input_);
  assign w_s1_g     = P1_W'(distortion_gain);
  assign w_s1_prod  = w_s1_x * w_s1_g;
  assign w_s1_shift = w_s1_prod >>> 8;
  assign w_s1_byp   = (mode == 2'd0) || (mode == 2'd3);

  // Saturate the gained sample to +-FS; -FS-1 is folded in too so the curve stays odd
  always_comb begin
    w_s1_sat = 1'b0;
    w_s1_p   = w_s1_shift[DATA_W-1:0];
    if (w_s1_shift > S1_MAX) begin
      w_s1_sat = 1'b1;
      w_s1_p   = D_MAX;
    end else if (w_s1_shift < S1_MIN) begin
      w_s1_sat = 1'b1;
      w_s1_p   = D_MIN;
    end
  end

  logic                     r1_valid, r1_byp, r1_hard, r1_sat;
  logic [CH_W-1:0]          r1_ch;
  logic signed [DATA_W-1:0] r1_p;
  logic [GAIN_W-1:0]        r1_boost;
  logic [DATA_W-2:0]        r1_cl;

  // Capture sample and its control words; bypass carries the raw sample untouched
  always_ff @(posedge clk) begin
    if (rst) r1_valid <= 1'b0;
    else     r1_valid <= in_valid;
    r1_ch    <= in_ch;
    r1_byp   <= w_s1_byp;
    r1_hard  <= (mode == 2'd1);
    r1_p     <= w_s1_byp ? input_ : w_s1_p;
    r1_sat   <= !w_s1_byp && w_s1_sat;
    r1_boost <= distortion_boost;
    r1_cl    <= clip_level;
  end

  // ---------------- S2: hard clamp, or square for the soft curve ----------------
  logic signed [DATA_W-1:0] w_s2_cl, w_s2_h;
  logic signed [SQ_W-1:0]   w_s2_sq;
  logic                     w_s2_over, w_s2_under;

  assign w_s2_cl    = {1'b0, r1_cl};
  assign w_s2_over  = r1_p > w_s2_cl;
  assign w_s2_under = r1_p < -w_s2_cl;
  assign w_s2_h     = w_s2_over ? w_s2_cl : (w_s2_under ? -w_s2_cl : r1_p);
  assign w_s2_sq    = SQ_W'(r1_p) * SQ_W'(r1_p);

  logic                     r2_valid, r2_byp, r2_hard, r2_evt;
  logic [CH_W-1:0]          r2_ch;
  logic signed [DATA_W-1:0] r2_v, r2_u2;
  logic [GAIN_W-1:0]        r2_boost;

  // r2_v is the clamped value in hard mode, otherwise u (or the raw bypass sample)
  always_ff @(posedge clk) begin
    if (rst) r2_valid <= 1'b0;
    else     r2_valid <= r1_valid;
    r2_ch    <= r1_ch;
    r2_byp   <= r1_byp;
    r2_hard  <= r1_hard;
    r2_v     <= r1_hard ? w_s2_h : r1_p;
    r2_u2    <= w_s2_sq[DATA_W-1 +: DATA_W];
    r2_evt   <= r1_sat || (r1_hard && (w_s2_over || w_s2_under));
    r2_boost <= r1_boost;
  end

  // ---------------- S3: cube ----------------
  logic signed [SQ_W-1:0] w_s3_cube;
  assign w_s3_cube = SQ_W'(r2_u2) * SQ_W'(r2_v);

  logic                     r3_valid, r3_byp, r3_hard, r3_evt;
  logic [CH_W-1:0]          r3_ch;
  logic signed [DATA_W-1:0] r3_v, r3_u3;
  logic [GAIN_W-1:0]        r3_boost;

  // u3 = u^3 in Q(DATA_W-1); the other fields just ride along
  always_ff @(posedge clk) begin
    if (rst) r3_valid <= 1'b0;
    else     r3_valid <= r2_valid;
    r3_ch    <= r2_ch;
    r3_byp   <= r2_byp;
    r3_hard  <= r2_hard;
    r3_v     <= r2_v;
    r3_u3    <= w_s3_cube[DATA_W-1 +: DATA_W];
    r3_evt   <= r2_evt;
    r3_boost <= r2_boost;
  end

  // ---------------- S4: s = (3u - u^3) / 2 ----------------
  logic signed [V_W-1:0] w_s4_u, w_s4_u3, w_s4_sum;
  assign w_s4_u   = V_W'(r3_v);
  assign w_s4_u3  = V_W'(r3_u3);
  assign w_s4_sum = (w_s4_u <<< 1) + w_s4_u - w_s4_u3;

  logic                  r4_valid, r4_byp, r4_evt;
  logic [CH_W-1:0]       r4_ch;
  logic signed [V_W-1:0] r4_v;
  logic [GAIN_W-1:0]     r4_boost;

  // Select shaped value; soft result may reach +-(FS+1) and is trimmed by S5 saturation
  always_ff @(posedge clk) begin
    if (rst) r4_valid <= 1'b0;
    else     r4_valid <= r3_valid;
    r4_ch    <= r3_ch;
    r4_byp   <= r3_byp;
    r4_v     <= (r3_byp || r3_hard) ? w_s4_u : (w_s4_sum >>> 1);
    r4_evt   <= r3_evt;
    r4_boost <= r3_boost;
  end

  // ---------------- S5: post-gain with symmetric saturation ----------------
  logic signed [P5_W-1:0]   w_s5_v, w_s5_b, w_s5_prod, w_s5_shift;
  logic signed [DATA_W-1:0] w_s5_y;

  assign w_s5_v     = P5_W'(r4_v);
  assign w_s5_b     = P5_W'(r4_boost);
  assign w_s5_prod  = w_s5_v * w_s5_b;
  assign w_s5_shift = w_s5_prod >>> 8;
  assign w_s5_y     = (w_s5_shift > S5_MAX) ? D_MAX :
                      (w_s5_shift < S5_MIN) ? D_MIN : w_s5_shift[DATA_W-1:0];

  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [DATA_W-1:0] r_out;

  // Output registers; data and tag hold during bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out       <= '0;
    end else begin
      r_out_valid <= r4_valid;
      if (r4_valid) begin
        r_out_ch <= r4_ch;
        r_out    <= r4_byp ? r4_v[DATA_W-1:0] : w_s5_y;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out       = r_out;

  logic w_unused;

`ifdef DIST_CLIP_STATS_EN
  logic [15:0] r_clip_count;

  // Saturating clip counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clip_clr)
      r_clip_count <= 16'h0000;
    else if (r4_valid && r4_evt && (r_clip_count != 16'hFFFF))
      r_clip_count <= r_clip_count + 16'h0001;
  end

  assign clip_count = r_clip_count;
  assign w_unused   = ^{w_s2_sq, w_s3_cube};
`else
  assign clip_count = 16'h0000;
  assign w_unused   = ^{w_s2_sq, w_s3_cube, clip_clr, r4_evt};
`endif

endmodule

// File: tb/tb_distortion_pipe.sv
// tb/tb_distortion_pipe.sv - self-checking bench for distortion_pipe (vector table, hand sequences, random vs reference model)
`timescale 1ns/1ps
module tb_distortion_pipe;

  localparam int CH_W = 1;
  localparam longint FS = 32767;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic signed [15:0] input_;
  logic [1:0]        mode;
  logic [15:0]       distortion_gain;
  logic [15:0]       distortion_boost;
  logic [14:0]       clip_level;
  logic              clip_clr;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic signed [15:0] out;
  logic [15:0]       clip_count;

  distortion_pipe #(.DATA_W(16), .GAIN_W(16), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .input_(input_),
    .mode(mode), .distortion_gain(distortion_gain), .distortion_boost(distortion_boost),
    .clip_level(clip_level), .clip_clr(clip_clr), .out_valid(out_valid),
    .out_ch(out_ch), .out(out), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected-output schedule indexed by bench iteration (ring of 8 > latency)
  bit              sv_v[8];
  longint          sv_y[8];
  logic [CH_W-1:0] sv_ch[8];
  bit              sv_evt[8];
  longint          m_out;
  logic [CH_W-1:0] m_ch;
  int              m_cnt;
  bit              rst_prev, clr_prev;
  int              cyc;

  typedef struct {
    int              md;
    longint          x;
    longint          g;
    longint          b;
    longint          cl;
    logic [CH_W-1:0] ch;
    longint          exp_y;
  } vec_t;

  vec_t tbl[17];
  logic signed [15:0] rx;
  longint ry;
  bit     re;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (iter %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic longint clampsym(input longint v);
    if (v > FS)  return FS;
    if (v < -FS) return -FS;
    return v;
  endfunction

  // Reference: the distortion rules in plain integer arithmetic
  function automatic longint ref_out(input int md, input longint x, input longint g,
                                     input longint b, input longint cl, output bit evt);
    longint t, p, v, u2, u3;
    evt = 1'b0;
    if (md == 0 || md == 3) return x;
    t   = (x * g) >>> 8;
    p   = clampsym(t);
    evt = (t != p);
    if (md == 1) begin
      if (p > cl)       begin v = cl;  evt = 1'b1; end
      else if (p < -cl) begin v = -cl; evt = 1'b1; end
      else              v = p;
    end else begin
      u2 = (p * p) >>> 15;
      u3 = (u2 * p) >>> 15;
      v  = (3 * p - u3) >>> 1;
    end
    return clampsym((v * b) >>> 8);
  endfunction

  // One clock: check outputs against the model, then drive the next inputs
  task automatic step(input bit v, input logic [CH_W-1:0] ch, input longint x, input int md,
                      input longint g, input longint b, input longint cl,
                      input bit clr, input bit r);
    int     slot;
    bit     ev;
    bit     e;
    longint y;
    @(negedge clk);
    slot = cyc % 8;
    ev   = 1'b0;
    if (rst_prev) begin
      for (int i = 0; i < 8; i++) sv_v[i] = 1'b0;
      m_out = 0; m_ch = '0; m_cnt = 0;
    end else if (sv_v[slot]) begin
      ev    = 1'b1;
      m_out = sv_y[slot];
      m_ch  = sv_ch[slot];
      if (clr_prev)                         m_cnt = 0;
      else if (sv_evt[slot] && m_cnt < 65535) m_cnt++;
      sv_v[slot] = 1'b0;
    end else if (clr_prev) begin
      m_cnt = 0;
    end
    chk("out_valid", out_valid, ev);
    chk("out", out, m_out);
    chk("out_ch", out_ch, m_ch);
`ifdef DIST_CLIP_STATS_EN
    chk("clip_count", clip_count, m_cnt);
`else
    chk("clip_count", clip_count, 0);
`endif
    in_valid         = v;
    in_ch            = ch;
    input_           = x[15:0];
    mode             = md[1:0];
    distortion_gain  = g[15:0];
    distortion_boost = b[15:0];
    clip_level       = cl[14:0];
    clip_clr         = clr;
    rst              = r;
    if (v && !r) begin
      y = ref_out(md, x, g, b, cl, e);
      sv_v[(cyc + 5) % 8]   = 1'b1;
      sv_y[(cyc + 5) % 8]   = y;
      sv_ch[(cyc + 5) % 8]  = ch;
      sv_evt[(cyc + 5) % 8] = e;
    end
    rst_prev = r;
    clr_prev = clr;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, '0, 0, 0, 256, 256, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; input_ = '0; mode = '0;
    distortion_gain = 16'h0100; distortion_boost = 16'h0100; clip_level = '0; clip_clr = 1'b0;
    for (int i = 0; i < 8; i++) sv_v[i] = 1'b0;
    m_out = 0; m_ch = '0; m_cnt = 0; rst_prev = 1'b1; clr_prev = 1'b0; cyc = 0;

    tbl[0]  = '{0, -1234,  512, 768, 16384, 1'b1, -1234};
    tbl[1]  = '{3, -32768, 256, 256, 0,     1'b0, -32768};
    tbl[2]  = '{1, 20000,  512, 256, 16384, 1'b0, 16384};
    tbl[3]  = '{1, -20000, 512, 256, 16384, 1'b1, -16384};
    tbl[4]  = '{2, 16384,  256, 256, 0,     1'b0, 22528};
    tbl[5]  = '{2, -16384, 256, 256, 0,     1'b1, -22528};
    tbl[6]  = '{2, 32767,  256, 256, 0,     1'b0, 32767};
    tbl[7]  = '{2, 0,      256, 256, 0,     1'b1, 0};
    tbl[8]  = '{2, 12345,  0,   256, 0,     1'b0, 0};
    tbl[9]  = '{1, 12345,  0,   256, 100,   1'b1, 0};
    tbl[10] = '{1, 5000,   256, 256, 0,     1'b0, 0};
    tbl[11] = '{1, 20000,  256, 512, 32767, 1'b1, 32767};
    tbl[12] = '{1, -20000, 256, 512, 32767, 1'b0, -32767};
    tbl[13] = '{1, -20000, 1024, 256, 32767, 1'b1, -32767};
    tbl[14] = '{1, 1000,   256, 256, 16384, 1'b0, 1000};
    tbl[15] = '{2, 8192,   256, 256, 0,     1'b1, 12032};
    tbl[16] = '{2, -32767, 256, 256, 0,     1'b0, -32767};

    repeat (2) @(posedge clk);
    step(1'b0, '0, 0, 0, 256, 256, 0, 1'b0, 1'b1);
    repeat (3) idle();

    // Isolated vectors: exact 5-cycle latency and hand-derived results
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].ch, tbl[i].x, tbl[i].md, tbl[i].g, tbl[i].b, tbl[i].cl, 1'b0, 1'b0);
      repeat (4) idle();
      chk("tbl_valid_early", out_valid, 0);
      idle();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_out", out, tbl[i].exp_y);
      chk("tbl_ch", out_ch, tbl[i].ch);
      idle();
      chk("tbl_valid_late", out_valid, 0);
    end

    // Back-to-back samples with mode switching every cycle
    for (int i = 0; i < 6; i++)
      step(1'b1, i[0], 16384, (i % 2 == 0) ? 1 : 2, 256, 256, 8192, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_out", out, (i % 2 == 0) ? 8192 : 22528);
      idle();
    end
    repeat (2) idle();

    // Reset with three samples in flight: none may emerge
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1000 + i, 1, 256, 256, 16384, 1'b0, 1'b0);
    step(1'b0, '0, 0, 0, 256, 256, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("rst_no_valid", out_valid, 0);
      chk("rst_out_zero", out, 0);
    end
    step(1'b1, 1'b1, -777, 2, 256, 256, 0, 1'b0, 1'b0);
    repeat (4) idle();
    chk("post_rst_early", out_valid, 0);
    idle();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_out", out, ref_out(2, -777, 256, 256, 0, re));

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      rx = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rx = ($urandom_range(0, 1) == 0) ? 16'sh7FFF : 16'sh8000;
      ry = rx;
      step($urandom_range(0, 3) != 0, CH_W'($urandom_range(0, 1)), ry, $urandom_range(0, 3),
           $urandom_range(0, 1024), $urandom_range(0, 768), $urandom_range(0, 32767),
           $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end
    repeat (6) idle();

`ifdef DIST_CLIP_STATS_EN
    step(1'b0, '0, 0, 0, 256, 256, 0, 1'b1, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1, '0, 100, 1, 256, 256, 0, 1'b0, 1'b0);
    repeat (5) idle();
    chk("cnt_saturated", clip_count, 16'hFFFF);
    step(1'b1, '0, 100, 1, 256, 256, 0, 1'b0, 1'b0);
    repeat (3) idle();
    step(1'b0, '0, 0, 0, 256, 256, 0, 1'b1, 1'b0);
    idle();
    chk("cnt_clr_valid", out_valid, 1);
    chk("cnt_clr_wins", clip_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
